// File: rtl/gpu_host_mem_port.sv
// gpu_host_mem_port: host-side sequencer for port B of the GPU dual-port RAM.
// Turns single-byte host req/busy/ack transactions into registered port-B
// accesses and waits out the RAM's registered read latency before acking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for host_req; a request in the ack cycle is accepted
// WRITE   | ram_wr_en_b high for exactly this cycle
// RD_WAIT | address held on port B, counting down the read latency
// MISS    | address outside the RAM window, ack with host_miss next
module gpu_host_mem_port #(
  parameter int          ADDR_SIZE  = 14,
  parameter int          NUM_WORDS  = 2**ADDR_SIZE,
  parameter logic [19:0] BASE_ADDR  = 20'h00000,
  parameter int          RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [19:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_busy,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_miss,
  output logic [19:0] ram_addr_b,
  output logic        ram_wr_en_b,
  output logic [7:0]  ram_data_b,
  input  logic [7:0]  ram_q_b
);

  localparam int               CNT_W     = $clog2(RD_LATENCY + 2);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(RD_LATENCY);
  localparam logic [20:0]      WIN_WORDS = 21'(NUM_WORDS);
  // Only the RAM's own address bits are ever driven onto port B.
  localparam logic [19:0]      ADDR_MASK = 20'((64'd1 << ADDR_SIZE) - 64'd1);

  typedef enum logic [1:0] {IDLE, WRITE, RD_WAIT, MISS} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             miss_rd, miss_rd_nxt;
  logic             ack_nxt, miss_nxt, wr_en_nxt;
  logic [7:0]       rdata_nxt, data_nxt;
  logic [19:0]      addr_nxt;

  logic [20:0] diff;
  logic [19:0] off;
  logic        in_window;

  // Window decode: the borrow of the 21-bit subtract flags addresses below BASE_ADDR.
  assign diff      = {1'b0, host_addr} - {1'b0, BASE_ADDR};
  assign off       = diff[19:0];
  assign in_window = !diff[20] && ({1'b0, off} < WIN_WORDS);

  assign host_busy = (state != IDLE);

  // State and output registers; reset drops ram_wr_en_b asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      miss_rd     <= 1'b0;
      host_ack    <= 1'b0;
      host_miss   <= 1'b0;
      host_rdata  <= 8'h00;
      ram_addr_b  <= 20'h00000;
      ram_wr_en_b <= 1'b0;
      ram_data_b  <= 8'h00;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      miss_rd     <= miss_rd_nxt;
      host_ack    <= ack_nxt;
      host_miss   <= miss_nxt;
      host_rdata  <= rdata_nxt;
      ram_addr_b  <= addr_nxt;
      ram_wr_en_b <= wr_en_nxt;
      ram_data_b  <= data_nxt;
    end
  end

  // Next-state and next-output decode; ack/miss/write-enable default low so each is a single-cycle pulse.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    miss_rd_nxt = miss_rd;
    ack_nxt     = 1'b0;
    miss_nxt    = 1'b0;
    wr_en_nxt   = 1'b0;
    rdata_nxt   = host_rdata;
    addr_nxt    = ram_addr_b;
    data_nxt    = ram_data_b;

    case (state)
      IDLE: begin
        if (host_req) begin
          if (in_window) begin
            addr_nxt = off & ADDR_MASK;
            if (host_wr) begin
              data_nxt  = host_wdata;
              wr_en_nxt = 1'b1;
              state_nxt = WRITE;
            end else begin
              cnt_nxt   = '0;
              state_nxt = RD_WAIT;
            end
          end else begin
            miss_rd_nxt = !host_wr;
            state_nxt   = MISS;
          end
        end
      end
      WRITE: begin
        ack_nxt   = 1'b1;
        state_nxt = IDLE;
      end
      RD_WAIT: begin
        if (cnt == CNT_LAST) begin
          rdata_nxt = ram_q_b;
          ack_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      MISS: begin
        ack_nxt  = 1'b1;
        miss_nxt = 1'b1;
        if (miss_rd) rdata_nxt = 8'hFF;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gpu_host_mem_port.sv
// Bench for gpu_host_mem_port with a two-stage registered RAM model on port B.
module tb_gpu_host_mem_port;

  localparam logic [19:0] BASE = 20'h10000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        host_req = 1'b0;
  logic        host_wr = 1'b0;
  logic [19:0] host_addr = 20'h0;
  logic [7:0]  host_wdata = 8'h0;
  logic        host_busy, host_ack, host_miss, ram_wr_en_b;
  logic [7:0]  host_rdata, ram_data_b, ram_q_b;
  logic [19:0] ram_addr_b;

  gpu_host_mem_port #(
    .ADDR_SIZE(14), .NUM_WORDS(16384), .BASE_ADDR(BASE), .RD_LATENCY(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_busy(host_busy), .host_ack(host_ack), .host_rdata(host_rdata), .host_miss(host_miss),
    .ram_addr_b(ram_addr_b), .ram_wr_en_b(ram_wr_en_b), .ram_data_b(ram_data_b), .ram_q_b(ram_q_b)
  );

  always #5 clk = ~clk;

  // RAM port B: address register then output register (read latency 2).
  logic [7:0]  mem [0:16383];
  logic [13:0] addr_q = 14'h0;
  logic [7:0]  q_r = 8'h0;
  assign ram_q_b = q_r;

  function automatic logic [7:0] pat(input int a);
    return 8'((a * 7 + 3) & 255);
  endfunction

  initial for (int i = 0; i < 16384; i++) mem[i] = pat(i);

  always @(posedge clk) begin
    if (ram_wr_en_b) mem[ram_addr_b[13:0]] <= ram_data_b;
    addr_q <= ram_addr_b[13:0];
    q_r    <= mem[addr_q];
  end

  typedef struct {
    string      tag;
    logic       is_rd;
    logic       miss;
    logic [7:0] rdata;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0, passed = 0, fails = 0;
  int wr_cnt = 0, ack_cnt = 0;
  int w0, a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle and tally pulse activity there.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (ram_wr_en_b) wr_cnt++;
    if (host_ack) ack_cnt++;
  endtask

  task automatic start(input logic wr, input logic [19:0] a, input logic [7:0] d);
    host_req   = 1'b1;
    host_wr    = wr;
    host_addr  = a;
    host_wdata = d;
    tick();
    host_req   = 1'b0;
  endtask

  task automatic push(input string tag, input logic is_rd, input logic miss,
                      input logic [7:0] rdata, input int lat);
    exp_t e;
    e.tag = tag; e.is_rd = is_rd; e.miss = miss; e.rdata = rdata; e.lat = lat;
    sb.push_back(e);
  endtask

  // Called in cycle n0 of a transaction; waits (bounded) for host_ack and scores it.
  task automatic await_ack(input int n0);
    exp_t e;
    int n = n0;
    int busy_c = 0;
    while (!host_ack && n < 40) begin
      if (host_busy) busy_c++;
      tick();
      n++;
    end
    if (sb.size() == 0) begin
      checks++;
      fails++;
      $error("FAIL sb_underflow: observed ack with no expected entry, required a queued entry");
    end else begin
      e = sb.pop_front();
      chk({e.tag, " ack"}, 32'(host_ack), 32'd1);
      chk({e.tag, " latency"}, n, e.lat);
      chk({e.tag, " busy_cycles"}, busy_c, e.lat - n0);
      chk({e.tag, " busy_at_ack"}, 32'(host_busy), 32'd0);
      chk({e.tag, " miss"}, 32'(host_miss), 32'(e.miss));
      if (e.is_rd) chk({e.tag, " rdata"}, 32'(host_rdata), 32'(e.rdata));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},  32'(host_busy), 32'd0);
    chk({tag, " ack"},   32'(host_ack), 32'd0);
    chk({tag, " miss"},  32'(host_miss), 32'd0);
    chk({tag, " rdata"}, 32'(host_rdata), 32'h00);
    chk({tag, " addr"},  32'(ram_addr_b), 32'h0);
    chk({tag, " wr_en"}, 32'(ram_wr_en_b), 32'd0);
    chk({tag, " data"},  32'(ram_data_b), 32'h00);
  endtask

  initial begin
    repeat (3) tick();
    chk_reset_vals("por");
    reset_n = 1'b1;
    tick();

    // Write 0x0123 <= A5
    w0 = wr_cnt;
    push("wr_0123", 1'b0, 1'b0, 8'h00, 2);
    start(1'b1, BASE + 20'h00123, 8'hA5);
    chk("wr c1 wr_en", 32'(ram_wr_en_b), 32'd1);
    chk("wr c1 addr", 32'(ram_addr_b), 32'h00123);
    chk("wr c1 data", 32'(ram_data_b), 32'hA5);
    chk("wr c1 busy", 32'(host_busy), 32'd1);
    await_ack(1);
    chk("wr c2 wr_en", 32'(ram_wr_en_b), 32'd0);
    chk("wr pulses", wr_cnt - w0, 1);
    tick();
    chk("wr ack single", 32'(host_ack), 32'd0);

    // Read back 0x0123
    w0 = wr_cnt;
    push("rd_0123", 1'b1, 1'b0, 8'hA5, 4);
    start(1'b0, BASE + 20'h00123, 8'h00);
    chk("rd c1 addr", 32'(ram_addr_b), 32'h00123);
    await_ack(1);
    chk("rd no wr_en", wr_cnt - w0, 0);

    // Read just below the window
    push("rd_miss_lo", 1'b1, 1'b1, 8'hFF, 2);
    start(1'b0, 20'h0FFFF, 8'h00);
    await_ack(1);
    chk("miss_lo addr held", 32'(ram_addr_b), 32'h00123);
    tick();
    chk("miss single", 32'(host_miss), 32'd0);

    // Write just above the window
    w0 = wr_cnt;
    push("wr_miss_hi", 1'b0, 1'b1, 8'h00, 2);
    start(1'b1, 20'h14000, 8'h11);
    await_ack(1);
    chk("miss_hi no wr_en", wr_cnt - w0, 0);
    chk("miss_hi data held", 32'(ram_data_b), 32'hA5);
    chk("miss_hi rdata held", 32'(host_rdata), 32'hFF);

    // Last in-window byte
    push("rd_top", 1'b1, 1'b0, pat(16383), 4);
    start(1'b0, 20'h13FFF, 8'h00);
    chk("rd_top addr", 32'(ram_addr_b), 32'h03FFF);
    await_ack(1);

    // Back-to-back: read issued in the write's ack cycle
    push("b2b_wr", 1'b0, 1'b0, 8'h00, 2);
    start(1'b1, BASE + 20'h00200, 8'h3C);
    await_ack(1);
    push("b2b_rd", 1'b1, 1'b0, 8'h3C, 4);
    start(1'b0, BASE + 20'h00200, 8'h00);
    chk("b2b c1 busy", 32'(host_busy), 32'd1);
    chk("b2b c1 addr", 32'(ram_addr_b), 32'h00200);
    await_ack(1);

    // Write pulsed while busy is dropped
    a0 = ack_cnt;
    w0 = wr_cnt;
    push("rd_drop", 1'b1, 1'b0, 8'hA5, 4);
    start(1'b0, BASE + 20'h00123, 8'h00);
    host_req = 1'b1; host_wr = 1'b1; host_addr = BASE + 20'h00300; host_wdata = 8'h77;
    tick();
    host_req = 1'b0;
    await_ack(2);
    repeat (4) tick();
    chk("drop ack count", ack_cnt - a0, 1);
    chk("drop no wr_en", wr_cnt - w0, 0);
    push("rd_0300", 1'b1, 1'b0, pat(16'h0300), 4);
    start(1'b0, BASE + 20'h00300, 8'h00);
    await_ack(1);

    // Reset during a write drops wr_en at once
    a0 = ack_cnt;
    start(1'b1, BASE + 20'h00400, 8'h99);
    reset_n = 1'b0;
    #1;
    chk("rst_wr wr_en", 32'(ram_wr_en_b), 32'd0);
    chk("rst_wr busy", 32'(host_busy), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("rst_wr no ack", ack_cnt - a0, 0);

    // Reset in cycle 2 of a read
    push("rd_pre", 1'b1, 1'b0, 8'hA5, 4);
    start(1'b0, BASE + 20'h00123, 8'h00);
    await_ack(1);
    a0 = ack_cnt;
    start(1'b0, BASE + 20'h00123, 8'h00);
    tick();
    reset_n = 1'b0;
    #1;
    chk_reset_vals("rst_rd");
    tick();
    tick();
    reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_rd no ack", ack_cnt - a0, 0);

    push("rd_post", 1'b1, 1'b0, 8'hA5, 4);
    start(1'b0, BASE + 20'h00123, 8'h00);
    await_ack(1);

    chk("sb empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
